poly_eval_arbiter: RTL and testbench



---
 rtl/poly_eval_arbiter_pkg.sv | 23 ++
 rtl/poly_eval_arbiter_if.sv | 29 ++
 rtl/poly_eval_arbiter_rr_pick.sv | 32 +++
 rtl/poly_eval_arbiter.sv | 130 +++++++++++++
 tb/tb_poly_eval_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/poly_eval_arbiter_pkg.sv
// Shared types and constants for the polynomial-evaluator arbiter.
package poly_arb_pkg;

  // Sequencer states for one evaluator service.
  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    ARM,
    WAIT_DONE,
    CAPTURE
  } state_e;

  // Default watchdog limit in cycles.
  localparam int TMO_DEFAULT = 255;

  // Watchdog counter width needed to hold any value 0..tmo.
  function automatic int wdog_width(input int tmo);
    return $clog2(tmo + 1);
  endfunction

  localparam int WDOG_W = wdog_width(TMO_DEFAULT);

endpackage

// File: rtl/poly_eval_arbiter_if.sv
// Requester-side and evaluator-side signals of the arbiter.
// master: the arbiter itself; slave: clients plus the evaluator.
interface poly_eval_arbiter_if #(
  parameter int NREQ = 4,
  parameter int XW   = 8,
  parameter int RW   = 16
);
  logic [NREQ-1:0]    req;
  logic [NREQ*XW-1:0] x_in;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    err;
  logic [RW-1:0]      result_out;
  logic               busy;
  logic               eval_start;
  logic [XW-1:0]      eval_x;
  logic               eval_ready;
  logic [RW-1:0]      eval_result;

  modport master (
    input  req, x_in, eval_ready, eval_result,
    output gnt, done, err, result_out, busy, eval_start, eval_x
  );

  modport slave (
    output req, x_in, eval_ready, eval_result,
    input  gnt, done, err, result_out, busy, eval_start, eval_x
  );
endinterface

// File: rtl/poly_eval_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request at or after rr_ptr.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [PW-1:0]   win_idx,
  output logic            win_vld
);

  // Scan from the farthest offset back to rr_ptr so the nearest request wins.
  always_comb begin
    int j;
    j       = 0;
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        win_oh    = '0;
        win_oh[j] = 1'b1;
        win_idx   = PW'(j);
        win_vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/poly_eval_arbiter.sv
// Round-robin arbiter sharing one polynomial evaluator among NREQ clients,
// with start/ready sequencing, result return and a hung-evaluation watchdog.
module poly_eval_arbiter
  import poly_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int XW   = 8,
  parameter int RW   = 16,
  parameter int TMO  = 255
) (
  input  logic              clk,
  input  logic              rst,
  poly_eval_arbiter_if.master bus
);

  localparam int PW  = $clog2(NREQ);
  localparam int WDW = wdog_width(TMO);

  state_e          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win_idx;
  logic [WDW-1:0]  wdog;
  logic [NREQ-1:0] gnt_r;
  logic [NREQ-1:0] done_r;
  logic [NREQ-1:0] err_r;
  logic [RW-1:0]   result_r;
  logic            start_r;
  logic [XW-1:0]   x_r;

  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;
  logic            pick_vld;
  logic            wdog_expired;

  // Pointer to the requester just after idx, wrapping at NREQ.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    if (int'(idx) == NREQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  // Watchdog fires on the TMO-th cycle spent in ARM/WAIT_DONE.
  assign wdog_expired = (wdog == WDW'(TMO - 1));

  // Service sequencer: arbitrate, launch, track ready, capture or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      win_idx  <= '0;
      wdog     <= '0;
      gnt_r    <= '0;
      done_r   <= '0;
      err_r    <= '0;
      result_r <= '0;
      start_r  <= 1'b0;
      x_r      <= '0;
    end else begin
      done_r  <= '0;
      err_r   <= '0;
      start_r <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld && bus.eval_ready) begin
            gnt_r   <= pick_oh;
            win_idx <= pick_idx;
            x_r     <= bus.x_in[int'(pick_idx)*XW +: XW];
            start_r <= 1'b1;
            state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          wdog  <= '0;
          state <= ARM;
        end
        ARM: begin
          if (wdog_expired) begin
            err_r  <= gnt_r;
            gnt_r  <= '0;
            rr_ptr <= next_ptr(win_idx);
            state  <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
            if (!bus.eval_ready) state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (wdog_expired) begin
            err_r  <= gnt_r;
            gnt_r  <= '0;
            rr_ptr <= next_ptr(win_idx);
            state  <= IDLE;
          end else if (bus.eval_ready) begin
            // Result and done land together so result_out is valid with done.
            result_r <= bus.eval_result;
            done_r   <= gnt_r;
            state    <= CAPTURE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        CAPTURE: begin
          gnt_r  <= '0;
          rr_ptr <= next_ptr(win_idx);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;
  assign bus.result_out = result_r;
  assign bus.eval_start = start_r;
  assign bus.eval_x     = x_r;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_poly_eval_arbiter.sv
// Bench for poly_eval_arbiter: evaluator stand-in, service-level model,
// per-cycle compare process and directed scenarios.
module tb_poly_eval_arbiter;

  localparam int N   = 4;
  localparam int XW  = 8;
  localparam int RW  = 16;
  localparam int TMO = 20;

  logic clk;
  logic rst;

  poly_eval_arbiter_if #(.NREQ(N), .XW(XW), .RW(RW)) bus ();

  poly_eval_arbiter #(.NREQ(N), .XW(XW), .RW(RW), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_start  = 0;

  int glog[$];
  int dlog[$];
  int elog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] poly(input logic [7:0] x);
    int v;
    v = int'(x) + 1;
    return 16'(v * v * v + 2);
  endfunction

  function automatic logic [31:0] oh(input int w);
    return 32'(1) << w;
  endfunction

  function automatic int rr_search(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Evaluator stand-in: busy for ev_runtime cycles after start, or forever while ev_hang.
  int          ev_runtime;
  bit          ev_hang;
  bit          ev_block;
  logic        ev_ready;
  int          ev_cnt;
  logic [15:0] ev_res;

  always @(posedge clk) begin
    if (rst) begin
      ev_ready <= 1'b1;
      ev_cnt   <= 0;
      ev_res   <= '0;
    end else if (ev_ready) begin
      if (bus.eval_start) begin
        ev_ready <= 1'b0;
        ev_cnt   <= ev_runtime;
      end
    end else if (!ev_hang) begin
      if (ev_cnt <= 1) begin
        ev_ready <= 1'b1;
        ev_res   <= poly(bus.eval_x);
      end else begin
        ev_cnt <= ev_cnt - 1;
      end
    end
  end

  assign bus.eval_ready  = ev_ready & ~ev_block;
  assign bus.eval_result = ev_res;

  always @(posedge clk) cyc <= cyc + 1;

  // Service-level model state.
  bit          prev_rst   = 1'b1;
  bit          prev_busy  = 1'b0;
  bit          prev_ready = 1'b0;
  logic [N-1:0] prev_req  = '0;
  logic [31:0] prev_xin   = '0;
  int          m_rr = 0;
  bit          m_act = 0;
  bit          m_cap = 0;
  int          m_w = 0;
  logic [7:0]  m_x = '0;
  int          m_sc = 0;
  int          m_rt = 0;
  bit          m_hang = 0;
  logic [15:0] m_res = '0;

  // Compare process: every cycle, DUT outputs against the service model.
  always @(negedge clk) begin
    int w;
    w = 0;
    if (prev_rst) begin
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_start", 32'(bus.eval_start), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_result", 32'(bus.result_out), 0);
      m_rr  = 0;
      m_act = 0;
      m_cap = 0;
      m_res = '0;
    end else begin
      if (bus.eval_start) n_start++;
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
      chk("done_onehot0", 32'($onehot0(bus.done)), 1);
      chk("err_onehot0", 32'($onehot0(bus.err)), 1);
      chk("done_err_excl", 32'(bus.done & bus.err), 0);
      chk("busy_vs_gnt", 32'(bus.busy), 32'(|bus.gnt));
      if (!prev_busy) begin
        chk("idle_no_pulse", 32'(bus.done | bus.err), 0);
        if (prev_ready && prev_req != '0) begin
          w      = rr_search(prev_req, m_rr);
          m_act  = 1;
          m_w    = w;
          m_x    = prev_xin[w*XW +: XW];
          m_sc   = cyc;
          m_rt   = ev_runtime;
          m_hang = ev_hang;
          glog.push_back(w);
          chk("grant", 32'(bus.gnt), oh(w));
          chk("launch_start", 32'(bus.eval_start), 1);
          chk("launch_x", 32'(bus.eval_x), 32'(m_x));
        end else begin
          chk("no_grant", 32'(bus.gnt), 0);
          chk("no_start", 32'(bus.eval_start), 0);
        end
      end else if (!m_act) begin
        chk("busy_without_service", 32'(prev_busy), 0);
      end else if (m_cap) begin
        chk("post_capture_gnt", 32'(bus.gnt), 0);
        chk("post_capture_done", 32'(bus.done), 0);
        chk("post_capture_err", 32'(bus.err), 0);
        m_cap = 0;
        m_act = 0;
      end else if (bus.err != '0) begin
        chk("err_target", 32'(bus.err), oh(m_w));
        chk("err_gnt_clear", 32'(bus.gnt), 0);
        chk("err_expected", 32'(m_hang), 1);
        chk("err_timing", 32'(cyc - m_sc), 32'(TMO + 1));
        chk("err_start", 32'(bus.eval_start), 0);
        m_rr  = (m_w + 1) % N;
        m_act = 0;
        elog.push_back(m_w);
      end else begin
        chk("gnt_hold", 32'(bus.gnt), oh(m_w));
        chk("x_hold", 32'(bus.eval_x), 32'(m_x));
        chk("start_once", 32'(bus.eval_start), 0);
        if (bus.done != '0) begin
          m_res = poly(m_x);
          chk("done_target", 32'(bus.done), oh(m_w));
          chk("done_timing", 32'(cyc - m_sc), 32'(m_rt + 2));
          chk("done_expected", 32'(m_hang), 0);
          m_rr  = (m_w + 1) % N;
          m_cap = 1;
          dlog.push_back(m_w);
        end else if (!m_hang) begin
          chk("done_late", 32'((cyc - m_sc) < (m_rt + 2)), 1);
        end else begin
          chk("err_late", 32'((cyc - m_sc) <= TMO), 1);
        end
      end
      chk("result_hold", 32'(bus.result_out), 32'(m_res));
    end
    prev_rst   = rst;
    prev_busy  = bus.busy;
    prev_ready = bus.eval_ready;
    prev_req   = bus.req;
    prev_xin   = bus.x_in;
  end

  // Wait on a log reaching a size; kind 0=grants, 1=dones, 2=errs.
  task automatic wait_cnt(input string name, input int kind, input int target, input int budget);
    bit ok;
    int n;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      n = (kind == 0) ? glog.size() : (kind == 1) ? dlog.size() : elog.size();
      if (n >= target) begin
        ok = 1;
        break;
      end
    end
    chk({name, "_wait"}, 32'(ok), 1);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int          base;
    logic [15:0] r_before;
    rst        = 1'b1;
    bus.req    = '0;
    bus.x_in   = '0;
    ev_runtime = 5;
    ev_hang    = 0;
    ev_block   = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_result_lit", 32'(bus.result_out), 0);
    chk("reset_gnt_lit", 32'(bus.gnt), 0);

    // Single requester, x=3, runtime 5.
    @(posedge clk);
    #1;
    bus.x_in = 32'h0000_0003;
    bus.req  = 4'b0001;
    wait_cnt("single_gnt", 0, 1, 20);
    chk("single_x_lit", 32'(bus.eval_x), 3);
    wait_cnt("single_done", 1, 1, 40);
    bus.req = '0;
    chk("single_target_lit", 32'(dlog[0]), 0);
    chk("single_result_lit", 32'(bus.result_out), 32'h0042);
    chk("single_start_cycles_lit", 32'(n_start), 1);
    repeat (3) @(posedge clk);

    // Contention from rr_ptr=0: order 0,1,2,3,0.
    do_reset();
    ev_runtime = 3;
    bus.x_in   = {8'd13, 8'd12, 8'd11, 8'd10};
    bus.req    = 4'b1111;
    base       = dlog.size();
    wait_cnt("contend_done", 1, base + 5, 200);
    bus.req = '0;
    chk("contend_0_lit", 32'(dlog[base+0]), 0);
    chk("contend_1_lit", 32'(dlog[base+1]), 1);
    chk("contend_2_lit", 32'(dlog[base+2]), 2);
    chk("contend_3_lit", 32'(dlog[base+3]), 3);
    chk("contend_4_lit", 32'(dlog[base+4]), 0);
    chk("contend_result_lit", 32'(bus.result_out), 32'd1333);

    // Fairness: serve 1, then 1 and 2 both held for 20 services.
    bus.req = 4'b0010;
    base    = dlog.size();
    wait_cnt("fair_first", 1, base + 1, 40);
    chk("fair_first_lit", 32'(dlog[base]), 1);
    bus.req = 4'b0110;
    base    = dlog.size();
    wait_cnt("fair_run", 1, base + 20, 400);
    bus.req = '0;
    for (int i = 0; i < 20; i++)
      chk($sformatf("fair_order_%0d", i), 32'(dlog[base+i]), (i % 2 == 0) ? 32'd2 : 32'd1);

    // Watchdog: evaluator never returns ready.
    repeat (2) @(posedge clk);
    #1;
    r_before = bus.result_out;
    ev_hang  = 1;
    bus.req  = 4'b0001;
    base     = elog.size();
    wait_cnt("wdog_err", 2, base + 1, TMO + 40);
    bus.req = '0;
    chk("wdog_target_lit", 32'(elog[base]), 0);
    chk("wdog_result_lit", 32'(bus.result_out), 32'(r_before));
    ev_hang = 0;
    repeat (10) @(posedge clk);
    #1;
    bus.req = 4'b1000;
    base    = dlog.size();
    wait_cnt("after_wdog_done", 1, base + 1, 40);
    bus.req = '0;
    chk("after_wdog_target_lit", 32'(dlog[base]), 3);

    // Reset in WAIT_DONE, with rr_ptr parked away from 0.
    bus.req = 4'b0010;
    base    = dlog.size();
    wait_cnt("pre_rst_done", 1, base + 1, 40);
    ev_runtime = 10;
    bus.req    = 4'b0100;
    base       = glog.size();
    wait_cnt("rst_gnt", 0, base + 1, 20);
    chk("rst_victim_lit", 32'(glog[base]), 2);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.req    = 4'b1111;
    ev_runtime = 3;
    @(negedge clk);
    chk("rst_mid_gnt_lit", 32'(bus.gnt), 0);
    chk("rst_mid_busy_lit", 32'(bus.busy), 0);
    chk("rst_mid_start_lit", 32'(bus.eval_start), 0);
    base = dlog.size();
    wait_cnt("post_rst_done", 1, base + 1, 40);
    bus.req = '0;
    chk("post_rst_target_lit", 32'(dlog[base]), 0);

    // Requester drops req and changes x during ARM.
    repeat (2) @(posedge clk);
    #1;
    bus.x_in = 32'h0000_0021;
    bus.req  = 4'b0001;
    base     = glog.size();
    wait_cnt("drop_gnt", 0, base + 1, 20);
    bus.req  = '0;
    bus.x_in = 32'h0000_0055;
    base     = dlog.size();
    wait_cnt("drop_done", 1, base + 1, 40);
    chk("drop_target_lit", 32'(dlog[base]), 0);
    chk("drop_result_lit", 32'(bus.result_out), 32'h998A);

    // Evaluator busy in IDLE: no grant until eval_ready rises.
    repeat (2) @(posedge clk);
    #1;
    ev_block = 1;
    bus.req  = 4'b0001;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("blocked_gnt_lit", 32'(bus.gnt), 0);
    @(posedge clk);
    #1 ev_block = 0;
    base = dlog.size();
    wait_cnt("unblock_done", 1, base + 1, 40);
    bus.req = '0;
    chk("unblock_target_lit", 32'(dlog[base]), 0);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
